// File: rtl/mem_pkg.sv
// Shared memory-stage types: store entries, store-buffer states and lane geometry.
package mem_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 4;

  // lanes[i] is cache byte lane i; lane 3 holds the lowest byte address (big-endian)
  typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

  typedef struct packed {
    logic [31:0]      addr;
    lanes_t           lanes;
    logic [LANES-1:0] be;
  } store_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store formatter: places word or byte store data into big-endian
// cache lanes with matching byte enables, and aligns the address to its word.
module store_lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0]      addr,
  input  logic [31:0]      data,
  input  logic             is_word,
  output logic [31:0]      word_addr,
  output lanes_t           lanes,
  output logic [LANES-1:0] be
);

  logic [1:0] lane_idx;

  // byte offset b lands in lane 3-b, which is the bitwise inverse of b
  assign lane_idx  = ~addr[1:0];
  assign word_addr = {addr[31:2], 2'b00};

  always_comb begin
    lanes = '0;
    be    = '0;
    if (is_word) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        lanes[i] = data[i*LANE_W +: LANE_W];
      end
      be = '1;
    end else begin
      lanes[lane_idx] = data[LANE_W-1:0];
      be[lane_idx]    = 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Memory-stage store FIFO: formats stores into cache lanes, issues them over req/ack
// and drains on halt. Optional macro STORE_BUFFER_LOAD_HAZARD_EN builds load overlap checks.
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic                     st_is_word,
  output logic                     cache_req,
  input  logic                     cache_ack,
  output logic [31:0]              cache_addr,
  output logic [LANE_W-1:0]        cache_wdata [0:LANES-1],
  output logic [LANES-1:0]         cache_be,
  input  logic [31:0]              ld_addr,
  output logic                     load_hazard,
  input  logic                     halted_controller,
  output logic                     drained,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  store_entry_t mem_q [DEPTH];
  ptr_t         rd_ptr_q, rd_ptr_d;
  ptr_t         wr_ptr_q, wr_ptr_d;
  cnt_t         count_q, count_d;
  sb_state_e    state_q, state_d;

  logic             full, empty, push, pop;
  logic [31:0]      fmt_addr;
  lanes_t           fmt_lanes;
  logic [LANES-1:0] fmt_be;
  store_entry_t     head;

  store_lane_fmt u_fmt (
    .addr      (st_addr),
    .data      (st_data),
    .is_word   (st_is_word),
    .word_addr (fmt_addr),
    .lanes     (fmt_lanes),
    .be        (fmt_be)
  );

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign st_ready  = !full && (state_q == RUN);
  assign cache_req = !empty && (state_q != DONE);
  assign push      = st_valid && st_ready;
  assign pop       = cache_req && cache_ack;
  assign drained   = (state_q == DONE);
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (push && !pop) begin
      count_d = count_q + cnt_t'(1);
    end else if (pop && !push) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halted_controller) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // no enqueues in DRAIN, so the last pop empties the buffer
        if (empty || (count_q == cnt_t'(1) && pop)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= '{addr: fmt_addr, lanes: fmt_lanes, be: fmt_be};
    end
  end

  always_comb begin
    cache_addr = '0;
    cache_be   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cache_wdata[i] = '0;
    end
    if (!empty) begin
      cache_addr = head.addr;
      cache_be   = head.be;
      for (int unsigned i = 0; i < LANES; i++) begin
        cache_wdata[i] = head.lanes[i];
      end
    end
  end

`ifdef STORE_BUFFER_LOAD_HAZARD_EN
  always_comb begin
    load_hazard = push && (fmt_addr[31:2] == ld_addr[31:2]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ptr_t slot_off;
      // entry i is live when its distance from the head is below the occupancy
      slot_off = ptr_t'(i) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q && mem_q[i].addr[31:2] == ld_addr[31:2]) begin
        load_hazard = 1'b1;
      end
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign load_hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_store_buffer;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, st_valid, st_ready, st_is_word;
  logic        cache_req, cache_ack, load_hazard, halted_controller, drained;
  logic [31:0] st_addr, st_data, cache_addr, ld_addr;
  logic [7:0]  cache_wdata [0:3];
  logic [3:0]  cache_be;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_addr           (st_addr),
    .st_data           (st_data),
    .st_is_word        (st_is_word),
    .cache_req         (cache_req),
    .cache_ack         (cache_ack),
    .cache_addr        (cache_addr),
    .cache_wdata       (cache_wdata),
    .cache_be          (cache_be),
    .ld_addr           (ld_addr),
    .load_hazard       (load_hazard),
    .halted_controller (halted_controller),
    .drained           (drained),
    .count             (count)
  );

  always #5 clk = ~clk;

`ifdef STORE_BUFFER_LOAD_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] lanes;  // {lane3, lane2, lane1, lane0}
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    bit          rst, v, w, ack;
    logic [31:0] a, d;
    int          e_count;
    bit          e_req, e_ready;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
  } vec_t;

  wr_t  q[$];
  int   mode;  // 0 running, 1 draining, 2 done
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [13];

  function automatic logic [31:0] wd_word();
    return {cache_wdata[3], cache_wdata[2], cache_wdata[1], cache_wdata[0]};
  endfunction

  function automatic wr_t fmt(logic [31:0] a, logic [31:0] d, bit w);
    wr_t r;
    int  sh;
    r.addr = a & 32'hFFFF_FFFC;
    sh     = 3 - int'(a & 32'h3);
    if (w) begin
      r.lanes = d;
      r.be    = 4'hF;
    end else begin
      r.lanes = {24'h0, d[7:0]} << (8 * sh);
      r.be    = 4'b0001 << sh;
    end
    return r;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(string name);
    bit  e_ready, e_req, e_haz;
    wr_t h;
    e_ready = (q.size() < DEPTH) && (mode == 0);
    e_req   = (q.size() > 0) && (mode != 2);
    h       = '{addr: 32'h0, lanes: 32'h0, be: 4'h0};
    if (q.size() > 0) h = q[0];
    e_haz = 1'b0;
    if (HAZ_EN) begin
      foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) e_haz = 1'b1;
      if (st_valid && e_ready && st_addr[31:2] == ld_addr[31:2]) e_haz = 1'b1;
    end
    cmp({name, ".ready"}, st_ready, e_ready);
    cmp({name, ".req"}, cache_req, e_req);
    cmp({name, ".count"}, count, q.size());
    cmp({name, ".addr"}, cache_addr, h.addr);
    cmp({name, ".wdata"}, wd_word(), h.lanes);
    cmp({name, ".be"}, cache_be, h.be);
    cmp({name, ".drained"}, drained, mode == 2);
    cmp({name, ".hazard"}, load_hazard, e_haz);
  endtask

  // Drive one cycle, check against the model before the edge, then advance both.
  task automatic cycle(bit v, logic [31:0] a, logic [31:0] d, bit w, bit ack, bit halt,
                       bit rst, logic [31:0] ld, string name);
    bit push, pop;
    st_valid = v; st_addr = a; st_data = d; st_is_word = w;
    cache_ack = ack; halted_controller = halt; reset = rst; ld_addr = ld;
    #1;
    check_model(name);
    push = v && (q.size() < DEPTH) && (mode == 0);
    pop  = (q.size() > 0) && (mode != 2) && ack;
    if (rst) begin
      q.delete();
      mode = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(fmt(a, d, w));
      if (mode == 0 && halt) mode = 1;
      else if (mode == 1 && q.size() == 0) mode = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit ack, string name);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, ack, 1'b0, 1'b0, 32'h0, name);
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_is_word = 1'b0;
    cache_ack = 1'b0; halted_controller = 1'b0; ld_addr = '0;
    q.delete();
    mode = 0;

    //          rst v  w  ack  addr          data          cnt req rdy addr         wdata         be
    tbl[0]  = '{1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 32'h0,    32'h0,        4'h0};
    tbl[1]  = '{0, 1, 0, 1, 32'h1001,     32'hFFFF_FFA5, 1, 1, 1, 32'h1000, 32'h00A5_0000, 4'b0100};
    tbl[2]  = '{0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 1, 32'h0,    32'h0,        4'h0};
    tbl[3]  = '{0, 1, 1, 0, 32'h2000,     32'h1122_3344, 1, 1, 1, 32'h2000, 32'h1122_3344, 4'hF};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 1, 32'h2000, 32'h1122_3344, 4'hF};
    tbl[5]  = '{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 1, 32'h2000, 32'h1122_3344, 4'hF};
    tbl[6]  = '{0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 1, 32'h2000, 32'h1122_3344, 4'hF};
    tbl[7]  = '{0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 1, 32'h0,    32'h0,        4'h0};
    tbl[8]  = '{0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 1, 32'h0,    32'h0,        4'h0};
    tbl[9]  = '{0, 1, 1, 0, 32'h2003,     32'hDEAD_BEEF, 1, 1, 1, 32'h2000, 32'hDEAD_BEEF, 4'hF};
    tbl[10] = '{0, 1, 0, 1, 32'h4000,     32'h0000_0012, 1, 1, 1, 32'h4000, 32'h1200_0000, 4'b1000};
    tbl[11] = '{0, 1, 0, 1, 32'h4003,     32'h0000_00AB, 1, 1, 1, 32'h4000, 32'h0000_00AB, 4'b0001};
    tbl[12] = '{0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 1, 32'h0,    32'h0,        4'h0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; st_valid = tbl[i].v; st_is_word = tbl[i].w;
      cache_ack = tbl[i].ack; st_addr = tbl[i].a; st_data = tbl[i].d;
      @(posedge clk);
      #1;
      cmp($sformatf("tbl%0d.count", i), count, tbl[i].e_count);
      cmp($sformatf("tbl%0d.req", i), cache_req, tbl[i].e_req);
      cmp($sformatf("tbl%0d.ready", i), st_ready, tbl[i].e_ready);
      cmp($sformatf("tbl%0d.addr", i), cache_addr, tbl[i].e_addr);
      cmp($sformatf("tbl%0d.wdata", i), wd_word(), tbl[i].e_wd);
      cmp($sformatf("tbl%0d.be", i), cache_be, tbl[i].e_be);
    end

    // Fill, full, then sustained enqueue+dequeue across the pointer wrap.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "fill.rst");
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "fill");
    cmp("full.count", count, 4);
    cmp("full.ready", st_ready, 1'b0);
    cycle(1'b1, 32'h900, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "full.blocked");
    idle(1'b1, "full.ack1");
    cmp("ack1.count", count, 3);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "wrap");
      cmp($sformatf("wrap%0d.count", i), count, 3);
    end
    for (int i = 0; i < 4; i++) idle(1'b1, "wrap.drain");

    // Halt drain with two stores queued.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "halt.rst");
    cycle(1'b1, 32'h500, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "halt.st0");
    cycle(1'b1, 32'h504, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "halt.st1");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, "halt.req");
    cmp("halt.ready", st_ready, 1'b0);
    cmp("halt.count1", count, 1);
    cycle(1'b1, 32'h508, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "halt.last");
    cmp("halt.drained", drained, 1'b1);
    cmp("halt.req0", cache_req, 1'b0);
    cycle(1'b1, 32'h50C, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, "halt.hold");
    cmp("halt.hold.drained", drained, 1'b1);
    cmp("halt.hold.count", count, 0);

    // Halt on an empty buffer: drained after the following edge.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "ehalt.rst");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "ehalt.n");
    cmp("ehalt.n.drained", drained, 1'b0);
    idle(1'b0, "ehalt.n1");
    cmp("ehalt.n1.drained", drained, 1'b1);

    // Reset mid-operation discards queued stores, overriding a same-cycle handshake.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "mrst.rst");
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h600 + 32'(i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "mrst.fill");
    cycle(1'b1, 32'h700, 32'h7, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, "mrst.pulse");
    cmp("mrst.count", count, 0);
    cmp("mrst.req", cache_req, 1'b0);
    cmp("mrst.ready", st_ready, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, "mrst.after");

    // Load hazard against a queued byte store at 0x3003.
    cycle(1'b1, 32'h3003, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "haz.st");
    st_valid = 1'b0; ld_addr = 32'h3000;
    #1;
    cmp("haz.same_word", load_hazard, HAZ_EN);
    ld_addr = 32'h3004;
    #1;
    cmp("haz.next_word", load_hazard, 1'b0);
    idle(1'b1, "haz.pop");

    // Randomized traffic against the reference model.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "rnd.rst");
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6, 32'h5000 | 32'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0,
            $urandom_range(0, 49) == 0, 32'h5000 | 32'($urandom_range(0, 15)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
